wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_if.sv | 28 ++
 rtl/wb_port_arbiter.sv | 77 +++++++
 tb/tb_wb_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: three writeback requesters plus register-file write port; slave = arbiter side, master = requester/RF side
interface wb_port_arbiter_if #(parameter int XLEN = 32);
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            aes_valid, aes_ready;
  logic [4:0]      aes_rd;
  logic [XLEN-1:0] aes_data;
  logic            rf_hold;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            sb_clr;
  logic [4:0]      sb_clr_rd;
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           aes_valid, aes_rd, aes_data, rf_hold,
    output alu_ready, lsu_ready, aes_ready, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rd
  );
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           aes_valid, aes_rd, aes_data, rf_hold,
    input  alu_ready, lsu_ready, aes_ready, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rd
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates ALU/LSU/AES results onto one register-file write port (clk, async active-low nrst, bus = wb_port_arbiter_if.slave, conflict_cnt = saturating contended-cycle count); `WB_ARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed LSU > AES > ALU
module wb_port_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  wb_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic [2:0]      in_v, bv, gnt, rdy;
  logic [4:0]      in_rd [3];
  logic [XLEN-1:0] in_dat [3];
  logic [4:0]      b_rd [3];
  logic [XLEN-1:0] b_dat [3];
  logic [1:0]      g_idx;
  logic            g_any, multi;
  assign in_v      = {bus.aes_valid, bus.lsu_valid, bus.alu_valid};
  assign in_rd[0]  = bus.alu_rd;
  assign in_rd[1]  = bus.lsu_rd;
  assign in_rd[2]  = bus.aes_rd;
  assign in_dat[0] = bus.alu_data;
  assign in_dat[1] = bus.lsu_data;
  assign in_dat[2] = bus.aes_data;
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr, c0, c1, c2;
  always_comb begin
    c0    = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    c1    = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    c2    = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    g_idx = bv[c0] ? c0 : bv[c1] ? c1 : c2;
  end
  // reset to AES so the first search starts at ALU
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) ptr <= 2'd2;
    else if (g_any) ptr <= g_idx;
`else
  assign g_idx = bv[1] ? 2'd1 : bv[2] ? 2'd2 : 2'd0;
`endif
  assign g_any = |bv && !bus.rf_hold;
  assign gnt   = g_any ? (3'b001 << g_idx) : 3'b000;
  // a granted buffer frees this cycle, so it can take a new result at the same edge
  assign rdy   = ~bv | gnt;
  assign multi = (bv[0] & bv[1]) | (bv[0] & bv[2]) | (bv[1] & bv[2]);
  assign bus.alu_ready = rdy[0];
  assign bus.lsu_ready = rdy[1];
  assign bus.aes_ready = rdy[2];
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      bv            <= '0;
      for (int i = 0; i < 3; i++) begin
        b_rd[i]  <= '0;
        b_dat[i] <= '0;
      end
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.sb_clr    <= 1'b0;
      bus.sb_clr_rd <= '0;
      conflict_cnt  <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (in_v[i] && rdy[i]) begin
          bv[i]    <= |in_rd[i];
          b_rd[i]  <= in_rd[i];
          b_dat[i] <= in_dat[i];
        end else if (gnt[i]) bv[i] <= 1'b0;
      bus.rf_we  <= g_any;
      bus.sb_clr <= g_any;
      if (g_any) begin
        bus.rf_waddr  <= b_rd[g_idx];
        bus.rf_wdata  <= b_dat[g_idx];
        bus.sb_clr_rd <= b_rd[g_idx];
      end
      if (multi && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scenario tasks drive the arbiter; expected writes queue up and are checked as rf_we fires
module tb_wb_port_arbiter;
  localparam int XLEN = 32;
  localparam int CW   = 4;
  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [CW-1:0] cnt;
  int            checks = 0;
  int            fails = 0;
  logic [36:0]   exp_q [$];
  logic [36:0]   e;
  wb_port_arbiter_if #(.XLEN(XLEN)) bus ();
  wb_port_arbiter #(.XLEN(XLEN), .CNT_W(CW)) dut (.clk(clk), .nrst(nrst), .bus(bus), .conflict_cnt(cnt));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  always @(negedge clk)
    if (nrst) begin
      checks++;
      if (bus.sb_clr !== bus.rf_we) begin
        fails++;
        $display("FAIL sb_clr_timing: sb_clr=%b rf_we=%b", bus.sb_clr, bus.rf_we);
      end
      if (bus.rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: rd=%0d data=%h, none expected", bus.rf_waddr, bus.rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rf_waddr, bus.rf_wdata} !== e || bus.sb_clr_rd !== e[36:32]) begin
            fails++;
            $display("FAIL write_data: rd=%0d clr_rd=%0d data=%h, exp rd=%0d data=%h",
                     bus.rf_waddr, bus.sb_clr_rd, bus.rf_wdata, e[36:32], e[31:0]);
          end
        end
      end
    end
  task automatic clr_in();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.aes_valid = 0; bus.aes_rd = 0; bus.aes_data = 0;
  endtask
  task automatic do_reset();
    clr_in();
    bus.rf_hold = 0;
    nrst = 0;
    @(negedge clk);
    nrst = 1;
    exp_q.delete();
  endtask
  task automatic drain(string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d writes outstanding, exp 0", name, exp_q.size());
    end
  endtask
  task automatic test_reset();
    clr_in();
    bus.rf_hold = 0;
    #1;
    checks++;
    if ({bus.rf_we, bus.sb_clr, bus.rf_waddr, bus.sb_clr_rd, bus.rf_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b clr=%b waddr=%0d clr_rd=%0d wdata=%h, exp all 0",
               bus.rf_we, bus.sb_clr, bus.rf_waddr, bus.sb_clr_rd, bus.rf_wdata);
    end
    checks++;
    if (cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", cnt); end
    checks++;
    if ({bus.aes_ready, bus.lsu_ready, bus.alu_ready} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ready: got %b exp 111", {bus.aes_ready, bus.lsu_ready, bus.alu_ready});
    end
    @(negedge clk);
    nrst = 1;
    @(negedge clk);
    checks++;
    if ({bus.aes_ready, bus.lsu_ready, bus.alu_ready, bus.rf_we} !== 4'b1110) begin
      fails++;
      $display("FAIL post_reset: ready=%b we=%b exp 111/0", {bus.aes_ready, bus.lsu_ready, bus.alu_ready}, bus.rf_we);
    end
  endtask
  task automatic test_single();
    @(negedge clk);
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    checks++;
    if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b exp 1", bus.alu_ready); end
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk);
    clr_in();
    checks++;
    if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL single_early: rf_we=%b exp 0", bus.rf_we); end
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5) begin
      fails++;
      $display("FAIL single_latency: rf_we=%b waddr=%0d exp 1/5", bus.rf_we, bus.rf_waddr);
    end
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_hold: rf_we=%b waddr=%0d wdata=%h exp 0/5/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  endtask
  task automatic test_zero_rd();
    @(negedge clk);
    bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h1234;
    checks++;
    if (bus.lsu_ready !== 1'b1) begin fails++; $display("FAIL zero_rd_ready: got %b exp 1", bus.lsu_ready); end
    @(negedge clk);
    clr_in();
    repeat (4) @(negedge clk);
    checks++;
    if (bus.lsu_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
      fails++;
      $display("FAIL zero_rd_empty: lsu_ready=%b rf_we=%b exp 1/0", bus.lsu_ready, bus.rf_we);
    end
  endtask
  task automatic test_all_three();
    do_reset();
    @(negedge clk);
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h101;
    bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h202;
    bus.aes_valid = 1; bus.aes_rd = 3; bus.aes_data = 32'h303;
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_q.push_back({5'd1, 32'h101}); exp_q.push_back({5'd2, 32'h202}); exp_q.push_back({5'd3, 32'h303});
`else
    exp_q.push_back({5'd2, 32'h202}); exp_q.push_back({5'd3, 32'h303}); exp_q.push_back({5'd1, 32'h101});
`endif
    @(negedge clk);
    clr_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL all_three_consec%0d: rf_we=%b exp 1", i, bus.rf_we); end
    end
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0 || cnt !== 4'd2) begin
      fails++;
      $display("FAIL all_three_end: rf_we=%b cnt=%0d exp 0/2", bus.rf_we, cnt);
    end
  endtask
  task automatic test_hold();
    do_reset();
    @(negedge clk);
    bus.rf_hold = 1;
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'hA1;
    @(negedge clk);
    bus.alu_rd = 8; bus.alu_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.alu_ready !== 1'b0 || bus.rf_we !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d: alu_ready=%b rf_we=%b exp 0/0", i, bus.alu_ready, bus.rf_we);
      end
      @(negedge clk);
    end
    bus.rf_hold = 0;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL hold_release_ready: got %b exp 1", bus.alu_ready); end
    exp_q.push_back({5'd7, 32'hA1});
    exp_q.push_back({5'd8, 32'hB2});
    @(negedge clk);
    clr_in();
    drain("hold");
  endtask
  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = $urandom;
      bus.alu_valid = 1; bus.alu_rd = 5'(10 + i); bus.alu_data = d;
      checks++;
      if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %b exp 1", i, bus.alu_ready); end
      exp_q.push_back({5'(10 + i), d});
    end
    @(negedge clk);
    clr_in();
    drain("b2b");
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    bus.rf_hold = 1;
    bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h44;
    bus.lsu_valid = 1; bus.lsu_rd = 6; bus.lsu_data = 32'h66;
    @(negedge clk);
    clr_in();
    checks++;
    if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_full: alu_ready=%b lsu_ready=%b exp 0/0", bus.alu_ready, bus.lsu_ready);
    end
    @(negedge clk);
    #2 nrst = 0;
    #1;
    checks++;
    if ({bus.rf_we, bus.sb_clr, bus.rf_waddr, bus.sb_clr_rd, bus.rf_wdata, cnt} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: waddr=%0d clr_rd=%0d wdata=%h cnt=%0d exp all 0",
               bus.rf_waddr, bus.sb_clr_rd, bus.rf_wdata, cnt);
    end
    checks++;
    if ({bus.aes_ready, bus.lsu_ready, bus.alu_ready} !== 3'b111) begin
      fails++;
      $display("FAIL mid_reset_ready: got %b exp 111", {bus.aes_ready, bus.lsu_ready, bus.alu_ready});
    end
    @(negedge clk);
    nrst = 1;
    bus.rf_hold = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0 || {bus.aes_ready, bus.lsu_ready, bus.alu_ready} !== 3'b111) begin
      fails++;
      $display("FAIL mid_after: rf_we=%b ready=%b exp 0/111", bus.rf_we, {bus.aes_ready, bus.lsu_ready, bus.alu_ready});
    end
  endtask
  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    bus.rf_hold = 1;
    bus.alu_valid = 1; bus.alu_rd = 9;  bus.alu_data = 32'h99;
    bus.lsu_valid = 1; bus.lsu_rd = 11; bus.lsu_data = 32'hBB;
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_q.push_back({5'd9, 32'h99}); exp_q.push_back({5'd11, 32'hBB});
`else
    exp_q.push_back({5'd11, 32'hBB}); exp_q.push_back({5'd9, 32'h99});
`endif
    @(negedge clk);
    clr_in();
    repeat ((1 << CW) + 5) @(negedge clk);
    checks++;
    if (cnt !== {CW{1'b1}}) begin fails++; $display("FAIL saturate: cnt=%0d exp %0d", cnt, (1 << CW) - 1); end
    bus.rf_hold = 0;
    drain("saturate");
    checks++;
    if (cnt !== {CW{1'b1}}) begin fails++; $display("FAIL saturate_hold: cnt=%0d exp %0d", cnt, (1 << CW) - 1); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_zero_rd();
    test_all_three();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
